// File: rtl/compmult_arbiter.sv
// Round-robin front end that shares one complex multiplier between N_CH requesters.
// A channel tag rides alongside each issue so the returned product is steered to its owner.
module compmult_arbiter #(
    parameter int A_DW     = 25,
    parameter int B_DW     = 18,
    parameter int N_CH     = 4,
    parameter int MULT_LAT = 4
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic [N_CH-1:0]               is_valid,
    output logic [N_CH-1:0]               os_ready,
    input  logic [N_CH*A_DW-1:0]          is_a_i,
    input  logic [N_CH*A_DW-1:0]          is_a_q,
    input  logic [N_CH*B_DW-1:0]          is_b_i,
    input  logic [N_CH*B_DW-1:0]          is_b_q,
    output logic                          ov_m,
    output logic [A_DW-1:0]               oa_i,
    output logic [A_DW-1:0]               oa_q,
    output logic [B_DW-1:0]               ob_i,
    output logic [B_DW-1:0]               ob_q,
    input  logic                          iv_m,
    input  logic [A_DW+B_DW:0]            ic_i,
    input  logic [A_DW+B_DW:0]            ic_q,
    output logic [N_CH-1:0]               om_valid,
    output logic [N_CH*(A_DW+B_DW+1)-1:0] om_c_i,
    output logic [N_CH*(A_DW+B_DW+1)-1:0] om_c_q,
    output logic                          oerr
);
    localparam int RW  = A_DW + B_DW + 1;
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DCW = $clog2(MULT_LAT + 1);

    logic [CW-1:0]          ptr_q;
    logic [CW-1:0]          gnt_idx;
    logic [CW-1:0]          cand;
    logic                   gnt_found;
    logic                   xfer;
    logic [DCW-1:0]         drain_q;
    logic                   draining;
    logic                   ov_q;
    logic [CW-1:0]          iss_ch_q;
    logic [A_DW-1:0]        oa_i_q, oa_q_q;
    logic [B_DW-1:0]        ob_i_q, ob_q_q;
    logic [MULT_LAT-1:0]    tag_v_q;
    logic [CW-1:0]          tag_ch_q [MULT_LAT];
    logic [N_CH-1:0]        om_valid_q;
    logic [N_CH*RW-1:0]     om_c_i_q, om_c_q_q;
    logic                   err_q;
    logic                   tag_out_v;
    logic [CW-1:0]          tag_out_ch;

    assign draining   = (drain_q != '0);
    assign tag_out_v  = tag_v_q[MULT_LAT-1];
    assign tag_out_ch = tag_ch_q[MULT_LAT-1];

    // First requester at or above the pointer, wrapping past the top channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = CW'((int'(ptr_q) + i) % N_CH);
            if (!gnt_found && is_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        os_ready = '0;
        if (gnt_found && !draining) os_ready[gnt_idx] = 1'b1;
    end

    assign xfer = gnt_found && !draining;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            ptr_q      <= '0;
            drain_q    <= DCW'(MULT_LAT);
            ov_q       <= 1'b0;
            iss_ch_q   <= '0;
            oa_i_q     <= '0;
            oa_q_q     <= '0;
            ob_i_q     <= '0;
            ob_q_q     <= '0;
            tag_v_q    <= '0;
            for (int i = 0; i < MULT_LAT; i++) tag_ch_q[i] <= '0;
            om_valid_q <= '0;
            om_c_i_q   <= '0;
            om_c_q_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (draining) drain_q <= drain_q - 1'b1;

            ov_q <= xfer;
            if (xfer) begin
                ptr_q    <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                iss_ch_q <= gnt_idx;
                oa_i_q   <= is_a_i[gnt_idx*A_DW +: A_DW];
                oa_q_q   <= is_a_q[gnt_idx*A_DW +: A_DW];
                ob_i_q   <= is_b_i[gnt_idx*B_DW +: B_DW];
                ob_q_q   <= is_b_q[gnt_idx*B_DW +: B_DW];
            end

            // Tags enter one cycle behind the issue so the last stage lines up with iv_m.
            tag_v_q[0]  <= ov_q;
            tag_ch_q[0] <= iss_ch_q;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_ch_q[i] <= tag_ch_q[i-1];
            end

            om_valid_q <= '0;
            if (tag_out_v) begin
                om_valid_q[tag_out_ch]        <= 1'b1;
                om_c_i_q[tag_out_ch*RW +: RW] <= ic_i;
                om_c_q_q[tag_out_ch*RW +: RW] <= ic_q;
            end

            if (!draining && (iv_m != tag_out_v)) err_q <= 1'b1;
        end
    end

    assign ov_m     = ov_q;
    assign oa_i     = oa_i_q;
    assign oa_q     = oa_q_q;
    assign ob_i     = ob_i_q;
    assign ob_q     = ob_q_q;
    assign om_valid = om_valid_q;
    assign om_c_i   = om_c_i_q;
    assign om_c_q   = om_c_q_q;
    assign oerr     = err_q;

endmodule

// File: tb/tb_compmult_arbiter.sv
// Bench for compmult_arbiter: a behavioural multiplier plus a scoreboard of expected
// results keyed by due cycle, driven by directed and random request patterns.
module tb_compmult_arbiter;
    localparam int A  = 25;
    localparam int B  = 18;
    localparam int N  = 4;
    localparam int L  = 4;
    localparam int RW = A + B + 1;

    logic              iclk, irst;
    logic [N-1:0]      is_valid, os_ready;
    logic [N*A-1:0]    is_a_i, is_a_q;
    logic [N*B-1:0]    is_b_i, is_b_q;
    logic              ov_m, iv_m, oerr;
    logic [A-1:0]      oa_i, oa_q;
    logic [B-1:0]      ob_i, ob_q;
    logic [RW-1:0]     ic_i, ic_q;
    logic [N-1:0]      om_valid;
    logic [N*RW-1:0]   om_c_i, om_c_q;

    compmult_arbiter #(.A_DW(A), .B_DW(B), .N_CH(N), .MULT_LAT(L)) dut (
        .iclk(iclk), .irst(irst), .is_valid(is_valid), .os_ready(os_ready),
        .is_a_i(is_a_i), .is_a_q(is_a_q), .is_b_i(is_b_i), .is_b_q(is_b_q),
        .ov_m(ov_m), .oa_i(oa_i), .oa_q(oa_q), .ob_i(ob_i), .ob_q(ob_q),
        .iv_m(iv_m), .ic_i(ic_i), .ic_q(ic_q),
        .om_valid(om_valid), .om_c_i(om_c_i), .om_c_q(om_c_q), .oerr(oerr)
    );

    always #5 iclk = ~iclk;

    function automatic logic [RW-1:0] cm_i(input logic signed [A-1:0] ai, input logic signed [A-1:0] aq,
                                           input logic signed [B-1:0] bi, input logic signed [B-1:0] bq);
        longint x;
        x = longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq);
        return x[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] cm_q(input logic signed [A-1:0] ai, input logic signed [A-1:0] aq,
                                           input logic signed [B-1:0] bi, input logic signed [B-1:0] bq);
        longint x;
        x = longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi);
        return x[RW-1:0];
    endfunction

    // Shared multiplier model; 'extra' adds one cycle of latency to provoke a tag mismatch.
    bit            extra;
    logic          mp_v [L+1];
    logic [RW-1:0] mp_i [L+1];
    logic [RW-1:0] mp_q [L+1];

    always @(posedge iclk) begin
        mp_v[0] <= ov_m;
        mp_i[0] <= cm_i(oa_i, oa_q, ob_i, ob_q);
        mp_q[0] <= cm_q(oa_i, oa_q, ob_i, ob_q);
        for (int k = 1; k <= L; k++) begin
            mp_v[k] <= mp_v[k-1];
            mp_i[k] <= mp_i[k-1];
            mp_q[k] <= mp_q[k-1];
        end
    end

    assign iv_m = extra ? mp_v[L] : mp_v[L-1];
    assign ic_i = extra ? mp_i[L] : mp_i[L-1];
    assign ic_q = extra ? mp_q[L] : mp_q[L-1];

    typedef struct {
        int            due;
        int            ch;
        logic [RW-1:0] ci;
        logic [RW-1:0] cq;
    } res_t;

    res_t     sbq[$];
    int       total, bad, cyc;
    int       mptr, mdrain;
    logic     exp_ov, merr;
    logic [A-1:0] e_ai, e_aq;
    logic [B-1:0] e_bi, e_bq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            is_a_i[k*A +: A] = A'($urandom);
            is_a_q[k*A +: A] = A'($urandom);
            is_b_i[k*B +: B] = B'($urandom);
            is_b_q[k*B +: B] = B'($urandom);
        end
    endtask

    task automatic do_cycle(input logic [N-1:0] vld);
        int           g;
        logic [N-1:0] er, eom;
        logic         tagv, nerr, n_ov;
        res_t         r;
        is_valid = vld;
        @(negedge iclk);
        g = -1;
        if (mdrain == 0)
            for (int i = 0; i < N; i++)
                if (g < 0 && vld[(mptr + i) % N]) g = (mptr + i) % N;
        er = (g >= 0) ? (N'(1) << g) : '0;
        chk("os_ready", 64'(os_ready), 64'(er));
        chk("ov_m", 64'(ov_m), 64'(exp_ov));
        chk("oa_i", 64'(oa_i), 64'(e_ai));
        chk("oa_q", 64'(oa_q), 64'(e_aq));
        chk("ob_i", 64'(ob_i), 64'(e_bi));
        chk("ob_q", 64'(ob_q), 64'(e_bq));
        eom = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            eom[sbq[0].ch] = 1'b1;
            if (!extra) begin
                chk("om_c_i", 64'(om_c_i[sbq[0].ch*RW +: RW]), 64'(sbq[0].ci));
                chk("om_c_q", 64'(om_c_q[sbq[0].ch*RW +: RW]), 64'(sbq[0].cq));
            end
            void'(sbq.pop_front());
        end
        chk("om_valid", 64'(om_valid), 64'(eom));
        chk("oerr", 64'(oerr), 64'(merr));
        tagv = 1'b0;
        foreach (sbq[j]) if (sbq[j].due == cyc + 1) tagv = 1'b1;
        nerr = merr | ((mdrain == 0) && (iv_m !== tagv));
        n_ov = 1'b0;
        if (g >= 0) begin
            r.due = cyc + L + 2;
            r.ch  = g;
            r.ci  = cm_i(is_a_i[g*A +: A], is_a_q[g*A +: A], is_b_i[g*B +: B], is_b_q[g*B +: B]);
            r.cq  = cm_q(is_a_i[g*A +: A], is_a_q[g*A +: A], is_b_i[g*B +: B], is_b_q[g*B +: B]);
            sbq.push_back(r);
            n_ov = 1'b1;
            mptr = (g + 1) % N;
        end
        @(posedge iclk);
        cyc++;
        exp_ov = n_ov;
        if (g >= 0) begin
            e_ai = is_a_i[g*A +: A];
            e_aq = is_a_q[g*A +: A];
            e_bi = is_b_i[g*B +: B];
            e_bq = is_b_q[g*B +: B];
        end
        merr = nerr;
        if (mdrain > 0) mdrain--;
        #1;
    endtask

    task automatic do_reset();
        irst = 1'b1;
        sbq.delete();
        mptr   = 0;
        mdrain = L;
        exp_ov = 1'b0;
        merr   = 1'b0;
        e_ai = '0; e_aq = '0; e_bi = '0; e_bq = '0;
        @(negedge iclk);
        chk("rst_ready", 64'(os_ready), 64'd0);
        chk("rst_ov_m", 64'(ov_m), 64'd0);
        chk("rst_oa_i", 64'(oa_i), 64'd0);
        chk("rst_om_valid", 64'(om_valid), 64'd0);
        chk("rst_om_c", 64'(|{om_c_i, om_c_q}), 64'd0);
        chk("rst_oerr", 64'(oerr), 64'd0);
        @(posedge iclk);
        cyc++;
        #1;
        irst   = 1'b0;
        mdrain = L;
    endtask

    // Reset, then hold every channel requesting through the drain window.
    task automatic reset_and_drain();
        do_reset();
        for (int i = 0; i < L; i++) do_cycle('1);
    endtask

    initial begin
        iclk = 1'b0; irst = 1'b1; is_valid = '0; extra = 1'b0;
        is_a_i = '0; is_a_q = '0; is_b_i = '0; is_b_q = '0;
        total = 0; bad = 0; cyc = 0;
        for (int k = 0; k <= L; k++) begin mp_v[k] = 1'b0; mp_i[k] = '0; mp_q[k] = '0; end

        // Single request on ch2: a=(3,-2), b=(1,4) gives (11,10) six cycles later.
        reset_and_drain();
        is_a_i[2*A +: A] = A'(3);
        is_a_q[2*A +: A] = A'(-2);
        is_b_i[2*B +: B] = B'(1);
        is_b_q[2*B +: B] = B'(4);
        do_cycle(4'b0100);
        for (int i = 0; i < L + 1; i++) do_cycle('0);
        chk("t1_valid", 64'(om_valid), 64'b0100);
        chk("t1_ci", 64'(om_c_i[2*RW +: RW]), 64'd11);
        chk("t1_cq", 64'(om_c_q[2*RW +: RW]), 64'd10);
        chk("t1_oerr", 64'(oerr), 64'd0);
        for (int i = 0; i < 3; i++) do_cycle('0);

        // Everyone requesting from pointer 0.
        reset_and_drain();
        for (int i = 0; i < 12; i++) begin rand_ops(); do_cycle('1); end
        for (int i = 0; i < L + 3; i++) do_cycle('0);

        // Move the pointer to 2, then ch1+ch3 wrap, then channels dropping out.
        reset_and_drain();
        rand_ops(); do_cycle(4'b0011);
        rand_ops(); do_cycle(4'b0011);
        rand_ops(); do_cycle(4'b1010);
        rand_ops(); do_cycle(4'b1010);
        rand_ops(); do_cycle(4'b1111);
        rand_ops(); do_cycle(4'b1011);
        rand_ops(); do_cycle(4'b0101);
        for (int i = 0; i < L + 3; i++) do_cycle('0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin rand_ops(); do_cycle(N'($urandom)); end
        for (int i = 0; i < L + 3; i++) do_cycle('0);

        // Reset with results in flight: none may come back and stale iv_m is ignored.
        for (int i = 0; i < 6; i++) begin rand_ops(); do_cycle('1); end
        reset_and_drain();
        for (int i = 0; i < L + 3; i++) do_cycle('0);
        chk("t4_oerr", 64'(oerr), 64'd0);

        // Multiplier one cycle late: oerr sets and sticks until reset.
        extra = 1'b1;
        for (int i = 0; i < 8; i++) begin rand_ops(); do_cycle('1); end
        chk("t5_oerr_set", 64'(oerr), 64'd1);
        for (int i = 0; i < 10; i++) do_cycle('0);
        chk("t5_oerr_hold", 64'(oerr), 64'd1);
        extra = 1'b0;
        reset_and_drain();
        for (int i = 0; i < 10; i++) begin rand_ops(); do_cycle(N'($urandom)); end
        for (int i = 0; i < L + 3; i++) do_cycle('0);
        chk("t5_oerr_clr", 64'(oerr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
